lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 125 ++++++++++++
 tb/tb_lsu_mem_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit port to a single-ported word memory: sub-word loads with extension,
// sub-word stores by read-modify-write. Optional misalignment trap: LSU_MISALIGN_CHECK_EN.
module lsu_mem_port #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              sgn;
        logic [ADDR_W-1:0] addr;
    } req_t;

    state_t      state_q, state_d;
    req_t        q;
    logic [31:0] rdata_q, wd_q;
    logic        misalign;
    logic        accept;

    assign accept = (state_q == IDLE) && req_valid;

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;
    // size 11 behaves as a word, so size[1] selects the word alignment rule
    assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);
    assign resp_err = err_q;
`else
    assign misalign = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misalign)       state_d = RESP;
                    else if (!req_we)   state_d = LOAD;
                    else if (req_size[1]) state_d = WRITE;
                    else                state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_ext, merged;

    always_comb begin
        byte_sel = mem_rd[{q.addr[1:0], 3'b000} +: 8];
        half_sel = q.addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (q.size)
            2'b00:   ld_ext = {{24{q.sgn & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{16{q.sgn & half_sel[15]}}, half_sel};
            default: ld_ext = mem_rd;
        endcase
        merged = mem_rd;
        if (q.size == 2'b00)
            merged[{q.addr[1:0], 3'b000} +: 8] = wd_q[7:0];
        else
            merged[{q.addr[1], 4'b0000} +: 16] = wd_q[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q       <= '0;
            rdata_q <= '0;
            wd_q    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                q.we    <= req_we;
                q.size  <= req_size;
                q.sgn   <= req_signed;
                q.addr  <= req_addr;
                wd_q    <= req_wdata;
                rdata_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
                err_q   <= misalign;
`endif
            end
            if (state_q == LOAD)   rdata_q <= ld_ext;
            if (state_q == RMW_RD) wd_q    <= merged;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign mem_we     = (state_q == WRITE);
    assign mem_a      = {q.addr[ADDR_W-1:2], 2'b00};
    assign mem_wd     = wd_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a 64-word behavioural memory.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];
    int          we_cnt = 0;
    logic [31:0] last_wa = '0;

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
            we_cnt  <= we_cnt + 1;
            last_wa <= mem_a;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for its response.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int nwe, output logic [31:0] ma1);
        int we0;
        @(negedge clk);
        check("ready_before_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        we0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ma1 = mem_a;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = resp_rdata;
        er  = resp_err;
        nwe = we_cnt - we0;
        @(posedge clk); #1;
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    int          lat, nwe, we0, idx, nresp;
    logic [31:0] rd, ma1;
    logic        er, rdy_prev;
    logic        bb_we [5];
    logic [1:0]  bb_sz [5];
    logic [31:0] bb_ad [5];
    logic [31:0] bb_wd [5];
    logic [31:0] bb_exp [5];
    logic [31:0] got [5];

    task automatic drive_bb(input int i);
        req_we = bb_we[i]; req_size = bb_sz[i]; req_signed = 1'b0;
        req_addr = bb_ad[i]; req_wdata = bb_wd[i];
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // word store then load back
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nwe, ma1);
        check("wst_lat", 32'(lat), 32'd2);
        check("wst_we_pulses", 32'(nwe), 32'd1);
        check("wst_addr", last_wa, 32'h10);
        check("wst_mem", mem[4], 32'hDEADBEEF);
        check("wst_rdata", rd, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nwe, ma1);
        check("wld_lat", 32'(lat), 32'd2);
        check("wld_rdata", rd, 32'hDEADBEEF);
        check("wld_no_we", 32'(nwe), 32'd0);
        check("wld_mem_a", ma1, 32'h10);

        // byte / half loads over 0x11223344
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, lat, rd, er, nwe, ma1);
        issue(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, lat, rd, er, nwe, ma1);
        check("sb_23", rd, 32'h00000011);
        issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, lat, rd, er, nwe, ma1);
        check("sb_20", rd, 32'h00000044);
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, rd, er, nwe, ma1);
        check("uh_22", rd, 32'h00001122);

        // sub-word stores via read-modify-write
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAB, lat, rd, er, nwe, ma1);
        check("bst_lat", 32'(lat), 32'd3);
        check("bst_we_pulses", 32'(nwe), 32'd1);
        check("bst_mem", mem[8], 32'h1122AB44);
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h12348000, lat, rd, er, nwe, ma1);
        check("hst_mem", mem[8], 32'h8000AB44);
        issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, rd, er, nwe, ma1);
        check("sh_22", rd, 32'hFFFF8000);
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, rd, er, nwe, ma1);
        check("uh_22b", rd, 32'h00008000);
        issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, lat, rd, er, nwe, ma1);
        check("sb_21", rd, 32'hFFFFFFAB);
        issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat, rd, er, nwe, ma1);
        check("ub_21", rd, 32'h000000AB);
        issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, lat, rd, er, nwe, ma1);
        check("size11_word", rd, 32'h8000AB44);

        // misaligned accesses
`ifdef LSU_MISALIGN_CHECK_EN
        issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, lat, rd, er, nwe, ma1);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(er), 32'd1);
        check("mis_rdata", rd, 32'd0);
        check("mis_no_we", 32'(nwe), 32'd0);
        issue(1'b1, 2'b01, 1'b0, 32'h23, 32'h5555, lat, rd, er, nwe, ma1);
        check("mis_st_err", 32'(er), 32'd1);
        check("mis_st_no_we", 32'(nwe), 32'd0);
        check("mis_st_mem", mem[8], 32'h8000AB44);
`else
        issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, lat, rd, er, nwe, ma1);
        check("mis_lat", 32'(lat), 32'd2);
        check("mis_err", 32'(er), 32'd0);
        check("mis_rdata", rd, 32'h8000AB44);
        check("mis_mem_a", ma1, 32'h20);
        issue(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, lat, rd, er, nwe, ma1);
        check("mis_half", rd, 32'h00008000);
`endif

        // reset during RMW_RD of a byte store
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h55667788, lat, rd, er, nwe, ma1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h31; req_wdata = 32'h99;
        we0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_busy", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_a", mem_a, 32'd0);
        check("mid_rst_mem_wd", mem_wd, 32'd0);
        check("mid_rst_resp", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_no_write", 32'(we_cnt - we0), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er, nwe, ma1);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_rdata", rd, 32'h55667788);

        // req_valid held high across alternating loads and stores
        bb_we  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bb_sz  = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
        bb_ad  = '{32'h10, 32'h34, 32'h34, 32'h35, 32'h34};
        bb_wd  = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h12, 32'h0};
        bb_exp = '{32'hDEADBEEF, 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFE120D};
        got    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        @(negedge clk);
        idx = 0; nresp = 0; we0 = we_cnt;
        drive_bb(0);
        req_valid = 1'b1;
        rdy_prev = req_ready;
        for (int c = 0; c < 80 && nresp < 5; c++) begin
            @(posedge clk); #1;
            if (rdy_prev && req_valid) begin
                idx++;
                if (idx < 5) drive_bb(idx);
                else req_valid = 1'b0;
            end
            if (resp_valid) begin
                if (nresp < 5) got[nresp] = resp_rdata;
                nresp++;
            end
            rdy_prev = req_ready;
        end
        req_valid = 1'b0;
        check("bb_accepts", 32'(idx), 32'd5);
        check("bb_resps", 32'(nresp), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("bb_rdata%0d", i), got[i], bb_exp[i]);
        check("bb_we_pulses", 32'(we_cnt - we0), 32'd2);
        check("bb_mem", mem[13], 32'hCAFE120D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
